// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_addsub
//  Function : Pipelined signed add/subtract, one CHUNK-bit carry-lookahead
//             slice per stage, with valid/ready flow control.
//  Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow,
    output logic             carry_out
);

    localparam int         STAGES   = WIDTH / CHUNK;
    localparam logic [4:0] c_OP_SUB = 5'b00001;

    // Returns carries c[0..CHUNK]; c[0] is the chunk carry-in.
    function automatic logic [CHUNK:0] f_cla(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             cin
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             prop;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & prop);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & cin);
        end
        return c;
    endfunction

    logic             w_sub;
    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;

    // Any opcode other than SUB runs as ADD.
    assign w_sub   = (ctrl_ALUopcode == c_OP_SUB);
    assign w_b_eff = w_sub ? ~data_operandB : data_operandB;

    assign in_ready = !(out_valid && !out_ready);
    assign w_adv    = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI  = (k + 1) * CHUNK;
        localparam int REM = WIDTH - HI;

        logic             w_vld_in;
        logic             w_cin;
        logic [CHUNK-1:0] w_a;
        logic [CHUNK-1:0] w_b;
        logic [CHUNK-1:0] w_p;
        logic [CHUNK:0]   w_c;
        logic [CHUNK-1:0] w_s;
        logic [HI-1:0]    w_sum_nxt;
        logic             r_vld;
        logic             r_cout;
        logic [HI-1:0]    r_sum;

        if (k == 0) begin : g_first
            assign w_vld_in  = in_valid;
            assign w_cin     = w_sub;
            assign w_a       = data_operandA[CHUNK-1:0];
            assign w_b       = w_b_eff[CHUNK-1:0];
            assign w_sum_nxt = w_s;
        end else begin : g_next
            assign w_vld_in  = g_stage[k-1].r_vld;
            assign w_cin     = g_stage[k-1].r_cout;
            assign w_a       = g_stage[k-1].g_skew.r_a[CHUNK-1:0];
            assign w_b       = g_stage[k-1].g_skew.r_b[CHUNK-1:0];
            assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
        end

        assign w_c = f_cla(w_a, w_b, w_cin);
        assign w_p = w_a ^ w_b;
        assign w_s = w_p ^ w_c[CHUNK-1:0];

        // Bubbles leave data untouched so the outputs hold while out_valid=0.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_vld  <= 1'b0;
                r_cout <= 1'b0;
                r_sum  <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld_in;
                if (w_vld_in) begin
                    r_cout <= w_c[CHUNK];
                    r_sum  <= w_sum_nxt;
                end
            end
        end

        // Operand chunks not yet resolved travel alongside their carry.
        if (REM > 0) begin : g_skew
            logic [REM-1:0] w_a_up;
            logic [REM-1:0] w_b_up;
            logic [REM-1:0] r_a;
            logic [REM-1:0] r_b;

            if (k == 0) begin : g_src_in
                assign w_a_up = data_operandA[WIDTH-1:CHUNK];
                assign w_b_up = w_b_eff[WIDTH-1:CHUNK];
            end else begin : g_src_prev
                assign w_a_up = g_stage[k-1].g_skew.r_a[REM+CHUNK-1:CHUNK];
                assign w_b_up = g_stage[k-1].g_skew.r_b[REM+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_vld_in) begin
                    r_a <= w_a_up;
                    r_b <= w_b_up;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_ovf <= 1'b0;
                end else if (w_adv && w_vld_in) begin
                    r_ovf <= w_c[CHUNK] ^ w_c[CHUNK-1];
                end
            end
        end
    end

    assign out_valid   = g_stage[STAGES-1].r_vld;
    assign data_result = g_stage[STAGES-1].r_sum;
    assign carry_out   = g_stage[STAGES-1].r_cout;
    assign overflow    = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK, with STAGES >= 1.
REQ-003 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and opcode present this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 data_operandA  input  WIDTH  signed operand A.
REQ-008 data_operandB  input  WIDTH  signed operand B.
REQ-009 ctrl_ALUopcode  input  5  00000 = ADD, 00001 = SUB.
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 data_result  output  WIDTH  A+B or A-B, modulo 2^WIDTH.
REQ-013 overflow  output  1  signed two's-complement overflow of data_result.
REQ-014 carry_out  output  1  unsigned carry out of the MSB; for SUB, 1 means no borrow.

Function
REQ-015 Transfer rules: an input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-016 Pipeline structure: the block SHALL be a STAGES-deep pipeline. Stage k resolves bits [k*CHUNK +: CHUNK] with a chunk-local carry-lookahead. The carry into stage k SHALL come from the stage k-1 register. Upper operand chunks SHALL be skewed through registers so that each chunk meets its carry.
REQ-017 SUB SHALL be computed as A + ~B with carry-in 1. ADD SHALL use carry-in 0.
REQ-018 Opcodes other than 00000 and 00001 SHALL be executed as ADD.
REQ-019 Latency: an operand accepted at rising edge N SHALL present out_valid=1 with its result after edge N+STAGES-1, i.e. visible in the cycle following edge N+STAGES-1. When STAGES=1 the result SHALL be visible in the cycle following the accepting edge.
REQ-020 Throughput SHALL be one operation per cycle when out_ready=1 continuously.
REQ-021 Stall: when out_valid=1 and out_ready=0, the pipeline SHALL stall.
  - in_ready SHALL be 0.
  - Every stage register, including partial sums and carries, SHALL hold its value.
  - Outputs SHALL be stable.
REQ-022 in_ready SHALL equal !(out_valid && !out_ready), combinationally.
REQ-023 Bubbles: per-stage valid bits SHALL track occupancy. A cycle with in_valid=0 SHALL insert a bubble that emerges as out_valid=0 after the same latency.
REQ-024 Simultaneous output transfer and input acceptance in one cycle SHALL be legal and SHALL lose no data.
REQ-025 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB, evaluated in the final stage.
REQ-026 Result ordering SHALL be strictly FIFO with respect to input acceptance.
REQ-027 While out_valid=0, data_result, overflow and carry_out SHALL hold their last values; verification SHALL NOT check them in that state.

Reset
REQ-028 While reset=0, every stage valid bit SHALL clear immediately (asynchronously), forcing out_valid=0.
REQ-029 While reset=0, data_result, overflow and carry_out SHALL be 0, and in_ready SHALL be 1.
REQ-030 Operations in flight when reset is asserted SHALL be discarded; no result for them SHALL appear after release.
REQ-031 The first rising edge with reset=1 SHALL be able to accept an operand.

Verification (WIDTH=32, CHUNK=8, STAGES=4)
REQ-032 Overflow on ADD: A=0x40000000, B=0x40000000, ADD, out_ready=1 -> result 4 cycles later: data_result=0x80000000, overflow=1, carry_out=0.
REQ-033 SUB without overflow: A=5, B=7, SUB -> data_result=0xFFFFFFFE (-2), overflow=0, carry_out=0. Then A=0x80000000, B=1, SUB -> data_result=0x7FFFFFFF, overflow=1, carry_out=1.
REQ-034 Cross-chunk carry: A=0x00FFFFFF, B=1, ADD -> data_result=0x01000000, overflow=0; A=0xFFFFFFFF, B=1 -> data_result=0, carry_out=1, overflow=0.
REQ-035 Streaming with back-pressure: stream 20 random operations with in_valid=1. Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 20 results correct, in order, none duplicated or dropped.
REQ-036 Reset mid-flight: accept 3 operations, assert reset=0 for 1 cycle before any result emerges -> out_valid=0 immediately, and no stale result appears afterwards. A new op (A=1, B=2, ADD) -> data_result=3 after 4 cycles.
